// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the instruction-fetch
// port and the load/store port; faulting accesses are caught before they reach memory.
module mem_arbiter #(
    parameter int unsigned MEM_BYTES = 32'd65536
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    output logic        i_err,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [2:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [2:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_exception,
    output logic        busy
);

    localparam logic [1:0]  ST_IDLE   = 2'd0;
    localparam logic [1:0]  ST_ACCESS = 2'd1;
    localparam logic [1:0]  ST_RESP   = 2'd2;
    localparam logic        GNT_I     = 1'b0;
    localparam logic        GNT_D     = 1'b1;
    localparam logic [2:0]  SZ_WORD   = 3'b010;
    localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

    // Size/alignment legality; undefined size codes always fault.
    function automatic logic size_fault(input logic [2:0] size, input logic [1:0] lsb);
        logic flt;
        case (size)
            3'b000, 3'b100: flt = 1'b0;
            3'b001, 3'b101: flt = lsb[0];
            3'b010:         flt = |lsb;
            default:        flt = 1'b1;
        endcase
        return flt;
    endfunction

    function automatic logic range_fault(input logic [31:0] addr);
        return ({1'b0, addr} >= MEM_LIMIT);
    endfunction

    logic [1:0]  state_r;
    logic [1:0]  state_nxt_s;
    logic        grant_r;
    logic        last_grant_r;
    logic        wr_lat_r;
    logic        fault_r;
    logic        mem_en_r;
    logic        mem_wr_r;
    logic [2:0]  mem_size_r;
    logic [31:0] mem_addr_r;
    logic [31:0] mem_wdata_r;
    logic        i_ack_r;
    logic        i_err_r;
    logic        d_ack_r;
    logic        d_err_r;

    logic        cand_i_s;
    logic        cand_d_s;
    logic        pick_d_s;
    logic        latch_s;
    logic [31:0] sel_addr_s;
    logic [2:0]  sel_size_s;
    logic        sel_wr_s;
    logic [31:0] sel_wdata_s;
    logic        sel_fault_s;
    logic        acc_fault_s;

    // Arbitration and selection of the winning request's attributes.
    always_comb begin
        cand_i_s = i_req;
        cand_d_s = d_req;
        // The requester being acknowledged still shows its old req this cycle.
        if (state_r == ST_RESP) begin
            if (grant_r == GNT_D) begin
                cand_d_s = 1'b0;
            end else begin
                cand_i_s = 1'b0;
            end
        end else begin
            cand_i_s = i_req;
            cand_d_s = d_req;
        end

        if (cand_i_s && cand_d_s) begin
            pick_d_s = (last_grant_r == GNT_I);
        end else begin
            pick_d_s = cand_d_s;
        end

        if ((state_r == ST_IDLE) || (state_r == ST_RESP)) begin
            latch_s = cand_i_s | cand_d_s;
        end else begin
            latch_s = 1'b0;
        end

        if (pick_d_s) begin
            sel_addr_s  = d_addr;
            sel_size_s  = d_size;
            sel_wr_s    = d_wr;
            sel_wdata_s = d_wdata;
        end else begin
            sel_addr_s  = i_addr;
            sel_size_s  = SZ_WORD;
            sel_wr_s    = 1'b0;
            sel_wdata_s = 32'd0;
        end

        sel_fault_s = size_fault(sel_size_s, sel_addr_s[1:0]) | range_fault(sel_addr_s);
        acc_fault_s = fault_r | (mem_en_r & mem_exception);
    end

    // Next-state decode for IDLE -> ACCESS -> RESP -> (ACCESS | IDLE).
    always_comb begin
        case (state_r)
            ST_IDLE:   state_nxt_s = latch_s ? ST_ACCESS : ST_IDLE;
            ST_ACCESS: state_nxt_s = ST_RESP;
            ST_RESP:   state_nxt_s = latch_s ? ST_ACCESS : ST_IDLE;
            default:   state_nxt_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Request latch: address/size stay put from ACCESS through RESP.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            grant_r      <= GNT_I;
            last_grant_r <= GNT_I;
            wr_lat_r     <= 1'b0;
            fault_r      <= 1'b0;
            mem_size_r   <= 3'd0;
            mem_addr_r   <= 32'd0;
            mem_wdata_r  <= 32'd0;
        end else if (latch_s) begin
            grant_r      <= pick_d_s;
            last_grant_r <= pick_d_s;
            wr_lat_r     <= sel_wr_s;
            fault_r      <= sel_fault_s;
            mem_size_r   <= sel_size_s;
            mem_addr_r   <= sel_addr_s;
            mem_wdata_r  <= sel_wdata_s;
        end else if (state_r == ST_ACCESS) begin
            fault_r      <= acc_fault_s;
        end else begin
            fault_r      <= fault_r;
        end
    end

    // Memory strobes are live only for the single ACCESS cycle of a clean request.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mem_en_r <= 1'b0;
            mem_wr_r <= 1'b0;
        end else begin
            mem_en_r <= latch_s & ~sel_fault_s;
            mem_wr_r <= latch_s & sel_wr_s & ~sel_fault_s;
        end
    end

    // Response pulses, launched at the end of ACCESS so they land in RESP.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            i_ack_r <= 1'b0;
            i_err_r <= 1'b0;
            d_ack_r <= 1'b0;
            d_err_r <= 1'b0;
        end else if (state_r == ST_ACCESS) begin
            i_ack_r <= (grant_r == GNT_I);
            i_err_r <= (grant_r == GNT_I) & acc_fault_s;
            d_ack_r <= (grant_r == GNT_D);
            d_err_r <= (grant_r == GNT_D) & acc_fault_s;
        end else begin
            i_ack_r <= 1'b0;
            i_err_r <= 1'b0;
            d_ack_r <= 1'b0;
            d_err_r <= 1'b0;
        end
    end

    // Read data arrives from the memory's own output register during RESP.
    assign i_rdata   = (i_ack_r && !i_err_r) ? mem_rdata : 32'd0;
    assign d_rdata   = (d_ack_r && !d_err_r && !wr_lat_r) ? mem_rdata : 32'd0;
    assign i_ack     = i_ack_r;
    assign i_err     = i_err_r;
    assign d_ack     = d_ack_r;
    assign d_err     = d_err_r;
    assign mem_en    = mem_en_r;
    assign mem_wr    = mem_wr_r;
    assign mem_size  = mem_size_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign busy      = (state_r != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: per-port expectation queues filled at issue time from
// a byte-array reference model, drained by a monitor whenever an ack appears.
module tb_mem_arbiter;

    logic        CLK;
    logic        RST_N;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        i_err;
    logic        d_req;
    logic        d_wr;
    logic [2:0]  d_size;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        mem_en;
    logic        mem_wr;
    logic [2:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_exception;
    logic        busy;

    mem_arbiter #(.MEM_BYTES(32'd65536)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_exception(mem_exception),
        .busy(busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [7:0] pat(input int k);
        return 8'(k * 37 + (k >> 8) * 11 + 5);
    endfunction

    // Memory environment: registered word read, lane formatting on the held addr/size,
    // and an exception window at 0x3000-0x30FF.
    logic [7:0]  tb_mem [0:65535];
    logic [31:0] raw_r;
    bit          mem_loaded = 1'b0;

    function automatic logic [31:0] fmt(input logic [31:0] raw, input logic [1:0] lane,
                                        input logic [2:0] sz);
        logic [31:0] sh;
        sh = raw >> {lane, 3'b000};
        case (sz)
            3'b000:  return {{24{sh[7]}}, sh[7:0]};
            3'b100:  return {24'd0, sh[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b101:  return {16'd0, sh[15:0]};
            default: return raw;
        endcase
    endfunction

    assign mem_exception = mem_en && (mem_addr[31:16] == 16'd0) && (mem_addr[15:8] == 8'h30);
    assign mem_rdata     = fmt(raw_r, mem_addr[1:0], mem_size);

    always @(posedge CLK) begin
        if (!mem_loaded) begin
            for (int k = 0; k < 65536; k++) tb_mem[k] <= pat(k);
            mem_loaded <= 1'b1;
        end else if (mem_en && mem_wr && !mem_exception) begin
            case (mem_size[1:0])
                2'b00: tb_mem[mem_addr[15:0]] <= mem_wdata[7:0];
                2'b01: begin
                    tb_mem[mem_addr[15:0]]         <= mem_wdata[7:0];
                    tb_mem[mem_addr[15:0] + 16'd1] <= mem_wdata[15:8];
                end
                2'b10: begin
                    tb_mem[mem_addr[15:0]]         <= mem_wdata[7:0];
                    tb_mem[mem_addr[15:0] + 16'd1] <= mem_wdata[15:8];
                    tb_mem[mem_addr[15:0] + 16'd2] <= mem_wdata[23:16];
                    tb_mem[mem_addr[15:0] + 16'd3] <= mem_wdata[31:24];
                end
                default: ;
            endcase
        end else if (mem_en && !mem_wr) begin
            raw_r <= {tb_mem[{mem_addr[15:2], 2'b11}], tb_mem[{mem_addr[15:2], 2'b10}],
                      tb_mem[{mem_addr[15:2], 2'b01}], tb_mem[{mem_addr[15:2], 2'b00}]};
        end
    end

    // Reference model: flat byte array and the access rules in plain arithmetic.
    logic [7:0] ref_mem [0:65535];

    function automatic int nbytes(input logic [2:0] sz);
        if (sz == 3'b010) return 4;
        if (sz == 3'b001 || sz == 3'b101) return 2;
        return 1;
    endfunction

    function automatic bit ref_fault(input logic [31:0] addr, input logic [2:0] sz);
        if (addr >= 32'h0001_0000) return 1'b1;
        if (sz == 3'b011 || sz == 3'b110 || sz == 3'b111) return 1'b1;
        if (addr % nbytes(sz) != 0) return 1'b1;
        if (addr >= 32'h3000 && addr < 32'h3100) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [2:0] sz);
        longint v;
        int     n;
        n = nbytes(sz);
        v = 0;
        for (int k = 0; k < n; k++) v += longint'(ref_mem[int'(addr) + k]) << (8 * k);
        if ((sz == 3'b000 || sz == 3'b001) && v >= (longint'(1) << (8 * n - 1)))
            v -= (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    task automatic ref_store(input logic [31:0] addr, input logic [2:0] sz, input logic [31:0] wd);
        for (int k = 0; k < nbytes(sz); k++) ref_mem[int'(addr) + k] = 8'(wd >> (8 * k));
    endtask

    typedef struct { logic [31:0] rdata; logic err; } exp_t;
    typedef struct { bit is_d; int cyc; } ev_t;
    exp_t        i_q[$];
    exp_t        d_q[$];
    ev_t         ack_log[$];
    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          cyc = 0;
    int          men_cnt = 0;
    int          i_start, d_start, i_lat, d_lat, t0, men0;
    logic [31:0] last_i_rdata, last_d_rdata;
    logic        last_i_err, last_d_err;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
    endtask

    task automatic i_op(input logic [31:0] addr);
        exp_t e;
        int   n;
        e.err   = ref_fault(addr, 3'b010);
        e.rdata = e.err ? 32'd0 : ref_load(addr, 3'b010);
        i_q.push_back(e);
        @(posedge CLK); #1;
        i_req = 1'b1; i_addr = addr; i_start = cyc;
        n = 0;
        do begin @(negedge CLK); n++; end while (!i_ack && n < 40);
        chk("i_ack_seen", 64'(i_ack), 64'd1);
        if (!i_ack) i_q.delete();
        i_lat = cyc - i_start;
        #1;
    endtask

    task automatic d_op(input logic wr, input logic [2:0] sz, input logic [31:0] addr,
                        input logic [31:0] wd);
        exp_t e;
        int   n;
        e.err   = ref_fault(addr, sz);
        e.rdata = 32'd0;
        if (!e.err && wr) ref_store(addr, sz, wd);
        if (!e.err && !wr) e.rdata = ref_load(addr, sz);
        d_q.push_back(e);
        @(posedge CLK); #1;
        d_req = 1'b1; d_wr = wr; d_size = sz; d_addr = addr; d_wdata = wd; d_start = cyc;
        n = 0;
        do begin @(negedge CLK); n++; end while (!d_ack && n < 40);
        chk("d_ack_seen", 64'(d_ack), 64'd1);
        if (!d_ack) d_q.delete();
        d_lat = cyc - d_start;
        #1;
    endtask

    task automatic i_idle();
        @(posedge CLK); #1; i_req = 1'b0;
    endtask

    task automatic d_idle();
        @(posedge CLK); #1; d_req = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctrl"}, 64'({i_ack, d_ack, i_err, d_err, mem_en, mem_wr, busy}), 64'd0);
        chk({tag, "_addr"}, 64'({mem_size, mem_addr}), 64'd0);
        chk({tag, "_wdata"}, 64'(mem_wdata), 64'd0);
        chk({tag, "_rdata"}, {i_rdata, d_rdata}, 64'd0);
    endtask

    task automatic tie_pair(input string tag);
        ack_log.delete();
        fork
            begin d_op(1'b0, 3'b010, 32'h1000, 32'd0); t0 = d_start;
                  d_op(1'b0, 3'b010, 32'h1004, 32'd0); d_idle(); end
            begin i_op(32'h100); i_op(32'h104); i_idle(); end
        join
        chk({tag, "_count"}, 64'(ack_log.size()), 64'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < ack_log.size()) begin
                chk({tag, "_port"}, 64'(ack_log[k].is_d), 64'(k % 2 == 0));
                chk({tag, "_cycle"}, 64'(ack_log[k].cyc), 64'(t0 + 2 + 2 * k));
            end
        end
    endtask

    initial begin
        RST_N = 1'b0; i_req = 1'b0; i_addr = 32'd0; d_req = 1'b0; d_wr = 1'b0;
        d_size = 3'd0; d_addr = 32'd0; d_wdata = 32'd0;
        for (int k = 0; k < 65536; k++) ref_mem[k] = pat(k);

        fork
            forever begin @(posedge CLK); cyc++; end
            begin : monitor
                exp_t me;
                forever begin
                    @(negedge CLK);
                    if (mem_en) men_cnt++;
                    chk("one_ack", 64'(i_ack & d_ack), 64'd0);
                    if (i_ack) begin
                        ack_log.push_back('{1'b0, cyc});
                        last_i_rdata = i_rdata; last_i_err = i_err;
                        chk("i_ack_expected", 64'(i_q.size() == 0), 64'd0);
                        if (i_q.size() != 0) begin
                            me = i_q.pop_front();
                            chk("i_resp", {31'd0, i_err, i_rdata}, {31'd0, me.err, me.rdata});
                        end
                    end else begin
                        chk("i_idle_zero", {31'd0, i_err, i_rdata}, 64'd0);
                    end
                    if (d_ack) begin
                        ack_log.push_back('{1'b1, cyc});
                        last_d_rdata = d_rdata; last_d_err = d_err;
                        chk("d_ack_expected", 64'(d_q.size() == 0), 64'd0);
                        if (d_q.size() != 0) begin
                            me = d_q.pop_front();
                            chk("d_resp", {31'd0, d_err, d_rdata}, {31'd0, me.err, me.rdata});
                        end
                    end else begin
                        chk("d_idle_zero", {31'd0, d_err, d_rdata}, 64'd0);
                    end
                end
            end
        join_none

        repeat (3) @(posedge CLK);
        #1;
        chk_all_zero("reset");
        RST_N = 1'b1;

        tie_pair("tie_from_reset");

        d_op(1'b1, 3'b010, 32'h10, 32'hDEADBEEF); d_idle();
        i_op(32'h10);
        chk("fetch_latency", 64'(i_lat), 64'd2);
        chk("fetch_data", {31'd0, last_i_err, last_i_rdata}, 64'h0_DEADBEEF);
        i_idle();

        d_op(1'b1, 3'b000, 32'h21, 32'h000000A5); d_idle();
        d_op(1'b0, 3'b100, 32'h21, 32'd0);
        chk("load_bu", 64'(last_d_rdata), 64'h000000A5);
        chk("load_latency", 64'(d_lat), 64'd2);
        d_idle();
        d_op(1'b1, 3'b000, 32'h22, 32'h00000080); d_idle();
        d_op(1'b0, 3'b000, 32'h22, 32'd0);
        chk("load_b_sext", 64'(last_d_rdata), 64'hFFFFFF80);
        d_idle();

        men0 = men_cnt;
        d_op(1'b1, 3'b010, 32'h6, 32'h11223344);
        chk("fault_misalign_err", 64'(last_d_err), 64'd1);
        d_op(1'b1, 3'b011, 32'h20, 32'h55667788);
        d_op(1'b0, 3'b011, 32'h20, 32'd0);
        d_op(1'b1, 3'b010, 32'h0001_0000, 32'hCAFEF00D);
        chk("fault_range_err", 64'(last_d_err), 64'd1);
        d_op(1'b1, 3'b001, 32'h0001_0000, 32'h0000BEEF);
        chk("fault_mem_en", 64'(men_cnt - men0), 64'd0);
        d_op(1'b0, 3'b010, 32'h4, 32'd0);
        d_op(1'b0, 3'b010, 32'h20, 32'd0);
        d_op(1'b0, 3'b010, 32'h0, 32'd0);
        d_idle();

        @(posedge CLK); #1;
        d_req = 1'b1; d_wr = 1'b0; d_size = 3'b010; d_addr = 32'h1004;
        @(posedge CLK); #1;
        chk("access_mem_en", 64'({mem_en, busy}), 64'd3);
        RST_N = 1'b0;
        #1;
        chk_all_zero("midop_reset");
        d_req = 1'b0;
        @(posedge CLK); #1;
        RST_N = 1'b1;
        tie_pair("tie_after_reset");

        fork
            begin
                for (int n = 0; n < 60; n++) begin
                    int r;
                    logic [31:0] a;
                    r = $urandom_range(0, 9);
                    if (r < 7)       a = {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
                    else if (r == 7) a = 32'h100 + 32'($urandom_range(1, 3));
                    else if (r == 8) a = 32'h3000 + {24'd0, 6'($urandom_range(0, 63)), 2'b00};
                    else             a = 32'h0001_0000 + {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
                    i_op(a);
                    if ($urandom_range(0, 2) != 0) begin
                        i_idle();
                        repeat ($urandom_range(0, 3)) @(posedge CLK);
                    end
                end
                i_idle();
            end
            begin
                for (int n = 0; n < 60; n++) begin
                    int r;
                    logic [2:0] sz;
                    logic [31:0] a;
                    r  = $urandom_range(0, 9);
                    sz = (r == 9) ? 3'($urandom_range(6, 7)) :
                         (r == 8) ? 3'b011 : 3'($urandom_range(0, 5));
                    if (sz == 3'b011 && r != 8) sz = 3'b100;
                    r = $urandom_range(0, 9);
                    if (r < 7)       a = 32'h1000 + 32'($urandom_range(0, 255));
                    else if (r == 7) a = 32'h3000 + 32'($urandom_range(0, 255));
                    else if (r == 8) a = 32'h0001_0000 + 32'($urandom_range(0, 255));
                    else             a = 32'hFFFF_FFF0;
                    d_op(1'($urandom_range(0, 1)), sz, a, $urandom);
                    if ($urandom_range(0, 2) != 0) begin
                        d_idle();
                        repeat ($urandom_range(0, 3)) @(posedge CLK);
                    end
                end
                d_idle();
            end
        join

        repeat (3) @(posedge CLK);
        #1;
        chk("i_queue_drained", 64'(i_q.size()), 64'd0);
        chk("d_queue_drained", 64'(d_q.size()), 64'd0);
        chk("final_idle", 64'(busy), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
